// File: rtl/rom_loader_if.sv
// Loader bus: flash-engine request/ack handshake plus the byte write port.
// master = rom_loader side, slave = flash engine / write sink side.
interface rom_loader_if #(
  parameter int unsigned A_BITS = 14
);
  logic              ldr_start;
  logic [15:0]       ldr_start_addr;
  logic [23:0]       ldr_flash_offset;
  logic [15:0]       ldr_amount;
  logic              ldr_busy;
  logic              ldr_req;
  logic              ldr_ack;
  logic [A_BITS-1:0] ldr_a;
  logic [7:0]        ldr_q;
  logic              wr_ready;
  logic              wr_strobe;
  logic [A_BITS-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output ldr_start, ldr_start_addr, ldr_flash_offset, ldr_amount, ldr_ack,
    output wr_strobe, wr_addr, wr_data,
    input  ldr_busy, ldr_req, ldr_a, ldr_q, wr_ready
  );

  modport slave (
    input  ldr_start, ldr_start_addr, ldr_flash_offset, ldr_amount, ldr_ack,
    input  wr_strobe, wr_addr, wr_data,
    output ldr_busy, ldr_req, ldr_a, ldr_q, wr_ready
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: boot-time sequencer copying REGIONS flash regions into on-chip
// memory through a toggle-handshake flash engine, one region after another.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (16-bit sum of written bytes);
// when undefined the checksum port is tied to zero.
module rom_loader #(
  parameter int unsigned            REGIONS       = 2,
  parameter int unsigned            A_BITS        = 14,
  parameter logic [16*REGIONS-1:0]  REGION_START  = {16'h8000, 16'h8000},
  parameter logic [24*REGIONS-1:0]  REGION_OFFSET = {24'h2000, 24'h0},
  parameter logic [16*REGIONS-1:0]  REGION_AMOUNT = {16'd8192, 16'd8192},
  parameter int unsigned            TIMEOUT       = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot_valid,
  input  logic        reload,
  rom_loader_if.master bus,
  output logic [2:0]  region,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam int unsigned CW = 17;

  typedef enum logic [2:0] {
    S_IDLE, S_SKIPCHK, S_START, S_WAIT_BUSY, S_RUN, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        region_q, region_d;
  logic              req_q, busy_q;
  logic              buf_full_q, buf_full_d;
  logic [A_BITS-1:0] buf_a_q, buf_a_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              end_pend_q, end_pend_d;
  logic              ack_q, ack_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [A_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              change_c, fall_c, write_c, clear_sum_c;
  logic [15:0]       start_addr_c, amount_c;
  logic [23:0]       offset_c;

  // Region table lookup for the current region
  always_comb begin
    start_addr_c = '0;
    offset_c     = '0;
    amount_c     = '0;
    for (int unsigned i = 0; i < REGIONS; i++) begin
      if (region_q == 3'(i)) begin
        start_addr_c = REGION_START[16*i +: 16];
        offset_c     = REGION_OFFSET[24*i +: 24];
        amount_c     = REGION_AMOUNT[16*i +: 16];
      end
    end
  end

  // Next-state, handshake and output decode
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    buf_full_d  = buf_full_q;
    buf_a_d     = buf_a_q;
    buf_data_d  = buf_data_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    end_pend_d  = end_pend_q;
    ack_d       = ack_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    change_c    = 1'b0;
    fall_c      = 1'b0;
    write_c     = 1'b0;
    clear_sum_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (slot_valid) state_d = S_SKIPCHK;
      end
      S_SKIPCHK: begin
        state_d = (amount_c == 16'd0) ? S_NEXT : S_START;
      end
      S_START: begin
        cnt_d      = '0;
        tmo_d      = TW'(1);  // counts cycles elapsed since the start pulse
        end_pend_d = 1'b0;
        buf_full_d = 1'b0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.ldr_busy) state_d = S_RUN;
        else if (tmo_q == TW'(TIMEOUT)) state_d = S_ERROR;
        else tmo_d = tmo_q + TW'(1);
      end
      S_RUN: begin
        change_c = (req_q != ack_q) && !buf_full_q;
        fall_c   = busy_q && !bus.ldr_busy;
        if (fall_c) end_pend_d = 1'b1;
        if (buf_full_q && (req_q == ack_q)) begin
          state_d = S_ERROR;  // source advanced while a byte was still held
        end else if (cnt_q > {1'b0, amount_c}) begin
          state_d = S_ERROR;
        end else if ((end_pend_q || fall_c) && !buf_full_q && !change_c) begin
          state_d = (cnt_q == {1'b0, amount_c}) ? S_NEXT : S_ERROR;
        end else if (change_c) begin
          buf_full_d = 1'b1;
          buf_a_d    = bus.ldr_a;
          buf_data_d = bus.ldr_q;
        end else if (buf_full_q && bus.wr_ready) begin
          write_c     = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = buf_a_q;
          wr_data_d   = buf_data_q;
          ack_d       = req_q;
          buf_full_d  = 1'b0;
          cnt_d       = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (region_q == 3'(REGIONS - 1)) begin
          state_d = S_DONE;
        end else begin
          region_d = region_q + 3'd1;
          state_d  = S_SKIPCHK;
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          region_d    = '0;
          clear_sum_c = 1'b1;
          state_d     = S_SKIPCHK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      region_q    <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_a_q     <= '0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      end_pend_q  <= 1'b0;
      ack_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      req_q       <= bus.ldr_req;
      busy_q      <= bus.ldr_busy;
      buf_full_q  <= buf_full_d;
      buf_a_q     <= buf_a_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      end_pend_q  <= end_pend_d;
      ack_q       <= ack_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running sum of every byte written, cleared on reload
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (clear_sum_c) begin
      checksum_q <= '0;
    end else if (write_c) begin
      checksum_q <= checksum_q + 16'(buf_data_q);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'd0;
`endif

  assign bus.ldr_start        = start_q;
  assign bus.ldr_start_addr   = start_addr_c;
  assign bus.ldr_flash_offset = offset_c;
  assign bus.ldr_amount       = amount_c;
  assign bus.ldr_ack          = ack_q;
  assign bus.wr_strobe        = wr_strobe_q;
  assign bus.wr_addr          = wr_addr_q;
  assign bus.wr_data          = wr_data_q;
  assign region               = region_q;
  assign done                 = done_q;
  assign error                = error_q;

endmodule
